io_intr_ctrl: RTL and testbench
===============================

Name: io_intr_ctrl

Overview:
- Interrupt controller for the IO subsystem. It collects interrupt requests from up to NUM_SRC IO devices, latches them as pending, and applies a mask.
- It picks the highest-priority unmasked request and runs the intr/inta handshake with the MIPS core.
- It presents the winning source ID and handler vector address to the core, and blocks further interrupts until the core signals end-of-interrupt (non-nested).

Parameters:
NUM_SRC, 8, number of interrupt sources (2..8)
ID_W, 3, width of source ID; must satisfy 2**ID_W >= NUM_SRC
VEC_BASE, 32'h0000_0200, byte address of source 0 handler vector; source n vector = VEC_BASE + 4*n

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
irq_in  input  NUM_SRC  device request lines, rising-edge sensitive
mask_wr  input  1  one-cycle strobe: load mask register from mask_din
mask_din  input  NUM_SRC  new mask value; 1 = source enabled
inta  input  1  interrupt acknowledge from core, rising-edge sensitive
eoi  input  1  one-cycle end-of-interrupt strobe from core
intr  output  1  interrupt request to core
vec_id  output  ID_W  ID of the source being acknowledged/serviced
vec_addr  output  32  handler vector address for vec_id
pending  output  NUM_SRC  pending register (raw, unmasked)
mask  output  NUM_SRC  current mask register
in_service  output  1  high from acknowledge capture until eoi

Behaviour:
- Reset (rst==0 at a clk edge) forces the following, regardless of state or mid-handshake:
  - intr=0, vec_id=0, vec_addr=VEC_BASE, pending=0, mask=0 (all disabled), in_service=0.
  - Edge-detect history registers are loaded with the current irq_in/inta, so a line already high at reset release does not register an edge.
  - State = IDLE.
- Edge detect: irq_rise[n] = irq_in[n] & ~irq_q[n]; inta_rise = inta & ~inta_q. irq_q and inta_q are registered every cycle.
- Pending:
  - pending[n] sets on the cycle after irq_rise[n].
  - pending[n] clears only when source n is captured at acknowledge.
  - If a rise and a clear of the same bit land in the same cycle, set wins.
  - Repeated rises while pending collapse into one pending event.
- Mask:
  - mask_wr loads mask on the next edge.
  - Masked sources still latch pending but do not take part in arbitration.
- Arbitration: req = pending & mask. The winner is the lowest index set in req (source 0 highest priority). Combinational, evaluated in IDLE only.
- FSM states IDLE, ASSERT, SERVICE:
  - IDLE: if req != 0, latch winner into win_id, set intr=1, go to ASSERT on the next edge. Latency from irq_in rising to intr high is 2 cycles.
  - ASSERT: intr held at 1; win_id frozen even if a higher-priority source arrives or the winner is masked meanwhile. On inta_rise:
    - intr=0, vec_id=win_id, vec_addr=VEC_BASE+{win_id,2'b00}, clear pending[win_id], in_service=1.
    - Go to SERVICE. All of these updates occur on the same edge.
  - SERVICE: intr=0. New requests keep accumulating in pending. On eoi: in_service=0, go to IDLE. The next request can raise intr 1 cycle after eoi. vec_id/vec_addr hold their value until the next acknowledge.
- Ignored inputs:
  - inta_rise in IDLE or SERVICE.
  - eoi in IDLE or ASSERT.
  - A level-high inta held across states does not re-acknowledge; an edge is required.
- Same-cycle events: mask_wr and arbitration in the same IDLE cycle use the old mask. irq_rise of win_id in the same cycle as its acknowledge leaves pending[win_id]=1 (set wins).

Test Plan:
- Reset and single request:
  - Stimulus: rst low 2 cycles, mask=8'hFF, pulse irq_in[3] at cycle 10.
  - Required: pending=8'h08 at cycle 11 and intr=1 at cycle 12.
  - Then assert inta: intr=0, vec_id=3, vec_addr=32'h20C, pending=0, in_service=1 one edge later.
  - Then pulse eoi: in_service=0.
- Priority and freeze:
  - Stimulus: irq_in[5] and irq_in[2] rise together.
  - Required: ack gives vec_id=2. After eoi, intr re-asserts 1 cycle later and ack gives vec_id=5.
  - Within the same test, raise irq_in[0] while in ASSERT for source 5: ack still gives vec_id=5.
- Masking:
  - Stimulus: mask=8'hFE, pulse irq_in[0].
  - Required: pending[0]=1 and intr stays 0 for 20 cycles.
  - Then write mask=8'hFF: intr=1 within 2 cycles, ack gives vec_id=0.
- Non-nesting and spurious handshakes:
  - Stimulus: during SERVICE pulse irq_in[1], inta, and a second inta.
  - Required: intr stays 0, vec_id unchanged, pending[1]=1.
  - Also: eoi while in IDLE leaves all outputs unchanged.
- Collapse and set-wins:
  - Stimulus: three irq_in[4] pulses while pending[4] is set.
  - Required: exactly one acknowledge for source 4.
  - Stimulus: irq_in[4] rising on the same edge as its acknowledge.
  - Required: pending[4]=1 afterwards, and a second service occurs after eoi.
- Reset mid-operation:
  - Stimulus: rst low for 1 cycle while in ASSERT with intr=1 and while in SERVICE.
  - Required: on the next edge intr=0, pending=0, mask=0, in_service=0, vec_addr=32'h200. Then no intr while irq_in is held high, until it falls and rises again.

Source files
------------

// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl: interrupt controller for the IO subsystem.
//   Latches rising edges on irq_in as pending and gates them with a mask.
//   The lowest-index unmasked pending source wins and drives a non-nested
//   intr/inta/eoi handshake with the core.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   irq_in            device request lines (rising-edge sensitive)
//   mask_wr/mask_din  mask load strobe and value (1 = enabled)
//   inta, eoi         acknowledge (rising edge) and end-of-interrupt strobe
//   intr              interrupt request to core
//   vec_id, vec_addr  acknowledged source and its handler vector address
//   pending, mask     raw pending register, current mask
//   in_service        high from acknowledge until eoi

// Per-source lane: edge detect plus pending bit. Set wins over clear.
module io_intr_lane (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pend
);
    logic irq_q;

    always_ff @(posedge clk) begin
        // History follows the line even in reset, so a line already high
        // at reset release does not look like an edge.
        irq_q <= irq;
        if (!rst) pend <= 1'b0;
        else      pend <= (pend & ~clr) | (irq & ~irq_q);
    end
endmodule

module io_intr_ctrl #(
    parameter int          NUM_SRC  = 8,
    parameter int          ID_W     = 3,
    parameter logic [31:0] VEC_BASE = 32'h0000_0200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               inta,
    input  logic               eoi,
    output logic               intr,
    output logic [ID_W-1:0]    vec_id,
    output logic [31:0]        vec_addr,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               in_service
);
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t             state, state_nxt;
    logic               inta_q;
    logic               inta_rise;
    logic               ack;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    arb_id;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] clr;

    assign inta_rise = inta & ~inta_q;
    assign ack       = (state == ASSERT) && inta_rise;
    assign req       = pending & mask;

    genvar n;
    generate
        for (n = 0; n < NUM_SRC; n++) begin : g_lane
            assign clr[n] = ack && (win_id == ID_W'(n));
            io_intr_lane u_lane (
                .clk  (clk),
                .rst  (rst),
                .irq  (irq_in[n]),
                .clr  (clr[n]),
                .pend (pending[n])
            );
        end
    endgenerate

    // Fixed priority: descending scan so the lowest set index is left last.
    always_comb begin
        arb_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (req[i]) arb_id = ID_W'(i);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req)     state_nxt = ASSERT;
            ASSERT:  if (inta_rise) state_nxt = SERVICE;
            SERVICE: if (eoi)       state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        inta_q <= inta;
        if (!rst) begin
            state    <= IDLE;
            win_id   <= '0;
            vec_id   <= '0;
            vec_addr <= VEC_BASE;
            mask     <= '0;
        end else begin
            state <= state_nxt;
            if (mask_wr) mask <= mask_din;
            // Winner is frozen once ASSERT is entered.
            if (state == IDLE && |req) win_id <= arb_id;
            if (ack) begin
                vec_id   <= win_id;
                vec_addr <= VEC_BASE + {{(30 - ID_W){1'b0}}, win_id, 2'b00};
            end
        end
    end

    assign intr       = (state == ASSERT);
    assign in_service = (state == SERVICE);
endmodule

// File: tb/tb_io_intr_ctrl.sv
module tb_io_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        mask_wr;
    logic [7:0]  mask_din;
    logic        inta;
    logic        eoi;
    logic        intr;
    logic [2:0]  vec_id;
    logic [31:0] vec_addr;
    logic [7:0]  pending;
    logic [7:0]  mask;
    logic        in_service;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    io_intr_ctrl #(.NUM_SRC(8), .ID_W(3), .VEC_BASE(32'h0000_0200)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
        .mask_din(mask_din), .inta(inta), .eoi(eoi), .intr(intr),
        .vec_id(vec_id), .vec_addr(vec_addr), .pending(pending),
        .mask(mask), .in_service(in_service)
    );

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_wr = 1'b1; mask_din = m; tick(); mask_wr = 1'b0;
    endtask

    // Acknowledge then end the current interrupt (drive only).
    task automatic ack_and_eoi();
        inta = 1'b1; tick(); inta = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; irq_in = '0; mask_wr = 1'b0; mask_din = '0; inta = 1'b0; eoi = 1'b0;
        tick(); tick();
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr got %b exp 0", intr); end
        n_chk++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got %h exp 00", pending); end
        n_chk++; if (mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask got %h exp 00", mask); end
        n_chk++; if (vec_addr !== 32'h200) begin n_fail++; $display("FAIL reset_vec_addr got %h exp 200", vec_addr); end
        n_chk++; if (vec_id !== 3'd0) begin n_fail++; $display("FAIL reset_vec_id got %0d exp 0", vec_id); end
        n_chk++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_in_service got %b exp 0", in_service); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        write_mask(8'hFF);
        n_chk++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL mask_load got %h exp ff", mask); end
        repeat (6) tick();
        irq_in[3] = 1'b1; tick(); irq_in = '0;
        n_chk++; if (pending !== 8'h08) begin n_fail++; $display("FAIL single_pending got %h exp 08", pending); end
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL single_intr_early got %b exp 0", intr); end
        tick();
        n_chk++; if (intr !== 1'b1) begin n_fail++; $display("FAIL single_intr got %b exp 1", intr); end
        inta = 1'b1; tick(); inta = 1'b0;
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL single_ack_intr got %b exp 0", intr); end
        n_chk++; if (vec_id !== 3'd3) begin n_fail++; $display("FAIL single_vec_id got %0d exp 3", vec_id); end
        n_chk++; if (vec_addr !== 32'h20C) begin n_fail++; $display("FAIL single_vec_addr got %h exp 20c", vec_addr); end
        n_chk++; if (pending !== 8'h00) begin n_fail++; $display("FAIL single_ack_pending got %h exp 00", pending); end
        n_chk++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL single_in_service got %b exp 1", in_service); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_chk++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL single_eoi got %b exp 0", in_service); end
    endtask

    task automatic test_priority();
        irq_in = 8'h24; tick(); irq_in = '0; tick();
        n_chk++; if (intr !== 1'b1) begin n_fail++; $display("FAIL prio_intr got %b exp 1", intr); end
        inta = 1'b1; tick(); inta = 1'b0;
        n_chk++; if (vec_id !== 3'd2) begin n_fail++; $display("FAIL prio_first got %0d exp 2", vec_id); end
        n_chk++; if (pending !== 8'h20) begin n_fail++; $display("FAIL prio_pending got %h exp 20", pending); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL prio_eoi_intr got %b exp 0", intr); end
        tick();
        n_chk++; if (intr !== 1'b1) begin n_fail++; $display("FAIL prio_reassert got %b exp 1", intr); end
        irq_in[0] = 1'b1; tick(); irq_in = '0;
        n_chk++; if (pending !== 8'h21) begin n_fail++; $display("FAIL prio_late_pending got %h exp 21", pending); end
        inta = 1'b1; tick(); inta = 1'b0;
        n_chk++; if (vec_id !== 3'd5) begin n_fail++; $display("FAIL prio_freeze got %0d exp 5", vec_id); end
        n_chk++; if (vec_addr !== 32'h214) begin n_fail++; $display("FAIL prio_addr got %h exp 214", vec_addr); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        ack_and_eoi();
        n_chk++; if (vec_id !== 3'd0) begin n_fail++; $display("FAIL prio_third got %0d exp 0", vec_id); end
    endtask

    task automatic test_masking();
        write_mask(8'hFE);
        irq_in[0] = 1'b1; tick(); irq_in = '0;
        n_chk++; if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL mask_pending got %b exp 1", pending[0]); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL mask_intr cyc %0d got %b exp 0", i, intr); end
        end
        write_mask(8'hFF); tick();
        n_chk++; if (intr !== 1'b1) begin n_fail++; $display("FAIL unmask_intr got %b exp 1", intr); end
        inta = 1'b1; tick(); inta = 1'b0;
        n_chk++; if (vec_id !== 3'd0) begin n_fail++; $display("FAIL unmask_vec got %0d exp 0", vec_id); end
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_non_nesting();
        irq_in[6] = 1'b1; tick(); irq_in = '0; tick();
        inta = 1'b1; tick(); inta = 1'b0;
        irq_in[1] = 1'b1; tick(); irq_in = '0;
        inta = 1'b1; tick(); inta = 1'b0; tick();
        inta = 1'b1; tick(); inta = 1'b0; tick();
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL nest_intr got %b exp 0", intr); end
        n_chk++; if (vec_id !== 3'd6) begin n_fail++; $display("FAIL nest_vec got %0d exp 6", vec_id); end
        n_chk++; if (pending !== 8'h02) begin n_fail++; $display("FAIL nest_pending got %h exp 02", pending); end
        n_chk++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL nest_in_service got %b exp 1", in_service); end
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        n_chk++; if (intr !== 1'b1) begin n_fail++; $display("FAIL nest_next_intr got %b exp 1", intr); end
        ack_and_eoi();
        // eoi while idle must be a no-op
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL idle_eoi_intr got %b exp 0", intr); end
        n_chk++; if (vec_id !== 3'd1) begin n_fail++; $display("FAIL idle_eoi_vec got %0d exp 1", vec_id); end
        n_chk++; if (vec_addr !== 32'h204) begin n_fail++; $display("FAIL idle_eoi_addr got %h exp 204", vec_addr); end
        n_chk++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL idle_eoi_insvc got %b exp 0", in_service); end
        n_chk++; if (pending !== 8'h00) begin n_fail++; $display("FAIL idle_eoi_pending got %h exp 00", pending); end
    endtask

    task automatic test_collapse_set_wins();
        irq_in[4] = 1'b1; tick(); irq_in = '0; tick();
        for (int i = 0; i < 2; i++) begin
            irq_in[4] = 1'b1; tick(); irq_in = '0; tick();
        end
        inta = 1'b1; tick(); inta = 1'b0;
        n_chk++; if (vec_id !== 3'd4) begin n_fail++; $display("FAIL collapse_vec got %0d exp 4", vec_id); end
        n_chk++; if (pending !== 8'h00) begin n_fail++; $display("FAIL collapse_pending got %h exp 00", pending); end
        eoi = 1'b1; tick(); eoi = 1'b0; tick(); tick();
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL collapse_second got %b exp 0", intr); end
        // rise on the acknowledge edge: set wins
        irq_in[4] = 1'b1; tick(); irq_in = '0; tick();
        irq_in[4] = 1'b1; inta = 1'b1; tick(); irq_in = '0; inta = 1'b0;
        n_chk++; if (vec_id !== 3'd4) begin n_fail++; $display("FAIL setwin_vec got %0d exp 4", vec_id); end
        n_chk++; if (pending !== 8'h10) begin n_fail++; $display("FAIL setwin_pending got %h exp 10", pending); end
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        n_chk++; if (intr !== 1'b1) begin n_fail++; $display("FAIL setwin_reassert got %b exp 1", intr); end
        ack_and_eoi();
        n_chk++; if (pending !== 8'h00) begin n_fail++; $display("FAIL setwin_cleared got %h exp 00", pending); end
    endtask

    task automatic test_reset_mid();
        irq_in[7] = 1'b1; tick(); irq_in = '0; tick();
        n_chk++; if (intr !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got %b exp 1", intr); end
        rst = 1'b0; irq_in = 8'h04; tick(); rst = 1'b1;
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rmid_a_intr got %b exp 0", intr); end
        n_chk++; if (pending !== 8'h00) begin n_fail++; $display("FAIL rmid_a_pending got %h exp 00", pending); end
        n_chk++; if (mask !== 8'h00) begin n_fail++; $display("FAIL rmid_a_mask got %h exp 00", mask); end
        n_chk++; if (vec_addr !== 32'h200) begin n_fail++; $display("FAIL rmid_a_addr got %h exp 200", vec_addr); end
        write_mask(8'hFF);
        repeat (3) tick();
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rmid_a_held got %b exp 0", intr); end
        n_chk++; if (pending !== 8'h00) begin n_fail++; $display("FAIL rmid_a_held_pend got %h exp 00", pending); end
        // now reset during SERVICE
        irq_in = '0; tick(); irq_in = 8'h04; tick(); tick();
        inta = 1'b1; tick();
        n_chk++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL rmid_s_pre got %b exp 1", in_service); end
        rst = 1'b0; tick(); rst = 1'b1;
        n_chk++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL rmid_s_insvc got %b exp 0", in_service); end
        n_chk++; if (vec_addr !== 32'h200) begin n_fail++; $display("FAIL rmid_s_addr got %h exp 200", vec_addr); end
        n_chk++; if (mask !== 8'h00) begin n_fail++; $display("FAIL rmid_s_mask got %h exp 00", mask); end
        inta = 1'b0;
        write_mask(8'hFF);
        repeat (3) tick();
        n_chk++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rmid_s_held got %b exp 0", intr); end
        irq_in = '0; tick(); irq_in = 8'h04; tick(); tick();
        n_chk++; if (intr !== 1'b1) begin n_fail++; $display("FAIL rmid_s_rerise got %b exp 1", intr); end
        inta = 1'b1; tick(); inta = 1'b0;
        n_chk++; if (vec_addr !== 32'h208) begin n_fail++; $display("FAIL rmid_s_addr2 got %h exp 208", vec_addr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_non_nesting();
        test_collapse_set_wins();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
